// File: rtl/bounce_generator.sv
// bounce_generator: switch-bounce emulator. It turns a clean requested switch
// level into a bouncing waveform on sw, then holds the requested level steady
// until the settled pulse.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is !busy. Requests offered while busy are
// dropped, not queued. This includes the cycle in which settled pulses.
//
// Glitch timing comes from a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1). It
// advances once per accepted request and once per tick while bouncing. All
// timing is counted in ticks of TICK_DIV clk cycles. sw only ever changes on
// the cycle after a tick.
//
// Optional feature, macro BOUNCE_GEN_RELEASE_BOUNCE_EN:
//   defined   - both 0->1 and 1->0 transitions bounce.
//   undefined - only 0->1 bounces. A 1->0 request drops sw cleanly on the
//               cycle after accept and goes straight to the settle hold.
module bounce_generator #(
  parameter int          TICK_DIV         = 100000,
  parameter int          BOUNCE_MIN_TICKS = 4,
  parameter int          RAND_BITS        = 3,
  parameter int          SETTLE_TICKS     = 20,
  parameter logic [15:0] SEED             = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_level,
  output logic       req_ready,
  output logic       sw,
  output logic       busy,
  output logic       settled,
  output logic [7:0] edge_cnt
);

`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
  localparam bit RELEASE_BOUNCE = 1'b1;
`else
  localparam bit RELEASE_BOUNCE = 1'b0;
`endif

  localparam int          TICK_W    = $clog2(TICK_DIV);
  localparam int          WIN_W     = $clog2(BOUNCE_MIN_TICKS + (1 << RAND_BITS));
  localparam int          SET_W     = $clog2(SETTLE_TICKS + 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // state_q is left as a plain named register so checkers can bind to it
  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              target_q, target_d;
  logic              sw_q, sw_d;
  logic [7:0]        edge_q, edge_d;
  logic [WIN_W-1:0]  win_q, win_d, win_dec;
  logic [2:0]        seg_q, seg_d, seg_dec;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              tick;
  logic              accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready;
  assign tick      = busy && (tick_q == TICK_W'(TICK_DIV - 1));
  assign sw        = sw_q;
  assign edge_cnt  = edge_q;
  assign win_dec   = win_q - WIN_W'(1);
  assign seg_dec   = seg_q - 3'd1;

  // Next-state and datapath: tick pacing, request accept, bounce and settle timing
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    lfsr_d   = lfsr_q;
    target_d = target_q;
    sw_d     = sw_q;
    edge_d   = edge_q;
    win_d    = win_q;
    seg_d    = seg_q;
    settle_d = settle_q;
    settled  = 1'b0;

    if (busy) begin
      tick_d = tick ? '0 : tick_q + TICK_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tick_d   = '0;
          lfsr_d   = lfsr_step(lfsr_q);
          target_d = req_level;
          edge_d   = '0;
          if (req_level == sw_q) begin
            // Already at the requested level: hold only, no edges
            state_d  = ST_SETTLE;
            settle_d = SET_W'(SETTLE_TICKS);
          end else if (!RELEASE_BOUNCE && !req_level) begin
            // Clean release: one edge right away, then the settle hold
            sw_d     = 1'b0;
            edge_d   = 8'd1;
            state_d  = ST_SETTLE;
            settle_d = SET_W'(SETTLE_TICKS);
          end else begin
            // Window and first segment come from the pre-advance LFSR bits
            state_d = ST_BOUNCE;
            win_d   = WIN_W'(BOUNCE_MIN_TICKS) + WIN_W'(lfsr_q[RAND_BITS-1:0]);
            seg_d   = 3'd1 + {1'b0, lfsr_q[15:14]};
          end
        end
      end

      ST_BOUNCE: begin
        if (tick) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (win_dec == '0) begin
            // Window expiry wins over a segment toggle on the same tick
            sw_d = target_q;
            if (sw_q != target_q) begin
              edge_d = sat_inc(edge_q);
            end
            settle_d = SET_W'(SETTLE_TICKS);
            state_d  = ST_SETTLE;
          end else begin
            win_d = win_dec;
            if (seg_dec == '0) begin
              sw_d   = !sw_q;
              edge_d = sat_inc(edge_q);
              seg_d  = 3'd1 + {1'b0, lfsr_q[15:14]};
            end else begin
              seg_d = seg_dec;
            end
          end
        end
      end

      ST_SETTLE: begin
        if (tick) begin
          settle_d = settle_q - SET_W'(1);
          if (settle_q == SET_W'(1)) begin
            settled = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      lfsr_q   <= SEED;
      target_q <= 1'b0;
      sw_q     <= 1'b0;
      edge_q   <= '0;
      win_q    <= '0;
      seg_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      sw_q     <= sw_d;
      edge_q   <= edge_d;
      win_q    <= win_d;
      seg_q    <= seg_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: bench for bounce_generator. It uses small tick
// parameters so that every operation lasts only a few dozen cycles.
//
// The model works at the level of ticks. For each accepted request it lists
// the sw level and edge count after every tick. It then expands that list
// into an expected queue with one entry per clk cycle:
// {sw, busy, settled, edge_cnt}.
module tb_bounce_generator;

  localparam int          TICK_DIV = 4;
  localparam int          BMIN     = 2;
  localparam int          RBITS    = 2;
  localparam int          SETTLE   = 3;
  localparam logic [15:0] SEED     = 16'hACE1;

`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
  localparam bit REL_BOUNCE = 1'b1;
`else
  localparam bit REL_BOUNCE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_level = 1'b0;
  logic       req_ready;
  logic       sw;
  logic       busy;
  logic       settled;
  logic [7:0] edge_cnt;

  always #5 clk = ~clk;

  bounce_generator #(
    .TICK_DIV        (TICK_DIV),
    .BOUNCE_MIN_TICKS(BMIN),
    .RAND_BITS       (RBITS),
    .SETTLE_TICKS    (SETTLE),
    .SEED            (SEED)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_level(req_level),
    .req_ready(req_ready),
    .sw       (sw),
    .busy     (busy),
    .settled  (settled),
    .edge_cnt (edge_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];
  logic        m_sw      = 1'b0;
  logic [15:0] m_lfsr    = SEED;
  bit          cyc_busy  = 1'b0;
  logic        last_sw   = 1'b0;
  logic [7:0]  last_ed   = 8'd0;
  int          n_pass    = 0;
  int          n_total   = 0;
  int          n_accepts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Tick-level reference for one accepted request
  task automatic model_accept(input logic lvl);
    logic [15:0] l0, cur;
    logic        s;
    int          edges, n_ticks, win, next_t, total, kk;
    logic        sw_after[0:15];
    int          ed_after[0:15];
    bit          bouncing;
    l0       = m_lfsr;
    cur      = lfsr_next(l0);
    s        = m_sw;
    edges    = 0;
    bouncing = 1'b0;
    win      = 0;
    next_t   = 1 + int'(l0[15:14]);
    if (lvl == m_sw) begin
      n_ticks = SETTLE;
    end else if (!REL_BOUNCE && !lvl) begin
      s       = 1'b0;
      edges   = 1;
      n_ticks = SETTLE;
    end else begin
      bouncing = 1'b1;
      win      = BMIN + int'(l0 & 16'((1 << RBITS) - 1));
      n_ticks  = win + SETTLE;
    end
    sw_after[0] = s;
    ed_after[0] = edges;
    for (int k = 1; k <= n_ticks; k++) begin
      if (bouncing && k <= win) begin
        if (k == win) begin
          if (s != lvl) edges = (edges < 255) ? edges + 1 : 255;
          s = lvl;
        end else if (k == next_t) begin
          s      = !s;
          edges  = (edges < 255) ? edges + 1 : 255;
          next_t = k + 1 + int'(cur[15:14]);
        end
        cur = lfsr_next(cur);
      end
      sw_after[k] = s;
      ed_after[k] = edges;
    end
    total = n_ticks * TICK_DIV;
    for (int j = 1; j <= total; j++) begin
      kk = (j - 1) / TICK_DIV;
      exp_q.push_back({sw_after[kk], 1'b1, (j == total), 8'(ed_after[kk])});
    end
    m_sw   = lvl;
    m_lfsr = cur;
  endtask

  // Model update on the same edge the DUT samples the request
  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_sw   = 1'b0;
      m_lfsr = SEED;
    end else if (req_valid && !cyc_busy) begin
      model_accept(req_level);
      n_accepts++;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin : cmp
    logic [10:0] exp_v;
    logic [10:0] act_v;
    act_v = {sw, busy, settled, edge_cnt};
    if (!reset) begin
      exp_v    = '0;
      cyc_busy = 1'b0;
      last_sw  = 1'b0;
      last_ed  = 8'd0;
    end else if (exp_q.size() != 0) begin
      exp_v    = exp_q.pop_front();
      cyc_busy = 1'b1;
      last_sw  = exp_v[10];
      last_ed  = exp_v[7:0];
    end else begin
      exp_v    = {last_sw, 2'b00, last_ed};
      cyc_busy = 1'b0;
    end
    check("cycle {sw,busy,settled,edge_cnt,req_ready}",
          32'({act_v, req_ready}), 32'({exp_v, !exp_v[9]}));
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic lvl, input int inject_at, output int lat, output int edges,
                        output int pulses, output logic sw1, output logic sw_end);
    lat    = 0;
    edges  = -1;
    pulses = 0;
    sw1    = 1'b0;
    sw_end = 1'b0;
    @(negedge clk);
    #1 req_valid = 1'b1;
    req_level = lvl;
    for (int j = 1; j <= 200 && pulses == 0; j++) begin
      @(negedge clk);
      if (j == 1) sw1 = sw;
      if (settled) begin
        pulses = 1;
        lat    = j;
        edges  = int'(edge_cnt);
        sw_end = sw;
      end
      #1 req_valid = (j == inject_at);
      req_level = !lvl;
    end
    req_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (settled) pulses++;
    end
  endtask

  task automatic press_then_reset(input int at_idx, output logic pre_sw, output logic pre_busy);
    @(negedge clk);
    #1 req_valid = 1'b1;
    req_level = 1'b1;
    @(negedge clk);
    #1 req_valid = 1'b0;
    repeat (at_idx - 1) @(negedge clk);
    pre_sw   = sw;
    pre_busy = busy;
    #2 reset = 1'b0;
    #1;
    check("async_reset sw", 32'(sw), 32'(0));
    check("async_reset busy", 32'(busy), 32'(0));
    check("async_reset req_ready", 32'(req_ready), 32'(1));
    check("async_reset edge_cnt", 32'(edge_cnt), 32'(0));
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat, edges, pulses;
    logic sw1, sw_end, pre_sw, pre_busy;

    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_reset sw", 32'(sw), 32'(0));
    check("post_reset busy", 32'(busy), 32'(0));
    check("post_reset req_ready", 32'(req_ready), 32'(1));
    check("post_reset edge_cnt", 32'(edge_cnt), 32'(0));

    // First press from SEED: window 3 ticks, one edge, settled at 24 cycles
    run_op(1'b1, 0, lat, edges, pulses, sw1, sw_end);
    check("press1 latency", 32'(lat), 32'(24));
    check("press1 edges", 32'(edges), 32'(1));
    check("press1 pulses", 32'(pulses), 32'(1));
    check("press1 final sw", 32'(sw_end), 32'(1));

    // Same level at 1
    run_op(1'b1, 0, lat, edges, pulses, sw1, sw_end);
    check("same1 latency", 32'(lat), 32'(12));
    check("same1 edges", 32'(edges), 32'(0));

    // Release
    run_op(1'b0, 0, lat, edges, pulses, sw1, sw_end);
`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
    check("release edges odd", 32'(edges % 2), 32'(1));
    check("release final sw", 32'(sw_end), 32'(0));
`else
    check("release latency", 32'(lat), 32'(12));
    check("release edges", 32'(edges), 32'(1));
    check("release sw after accept", 32'(sw1), 32'(0));
`endif

    // Same level at 0
    run_op(1'b0, 0, lat, edges, pulses, sw1, sw_end);
    check("same0 latency", 32'(lat), 32'(12));
    check("same0 edges", 32'(edges), 32'(0));

    // Press with a competing release request offered while busy
    run_op(1'b1, 3, lat, edges, pulses, sw1, sw_end);
    check("busy_drop pulses", 32'(pulses), 32'(1));
    check("busy_drop final sw", 32'(sw_end), 32'(1));
    check("busy_drop edges odd", 32'(edges % 2), 32'(1));
    check("busy_drop window", 32'(lat >= 20 && lat <= 32), 32'(1));

    // Back to 0, then reset in the middle of a bounce window
    run_op(1'b0, 0, lat, edges, pulses, sw1, sw_end);
    press_then_reset(6, pre_sw, pre_busy);
    check("mid_bounce busy before reset", 32'(pre_busy), 32'(1));

    // After reset the LFSR is back at SEED: sw is 1 and busy at cycle 16
    press_then_reset(16, pre_sw, pre_busy);
    check("mid_settle sw before reset", 32'(pre_sw), 32'(1));
    check("mid_settle busy before reset", 32'(pre_busy), 32'(1));

    run_op(1'b1, 0, lat, edges, pulses, sw1, sw_end);
    check("press_after_reset latency", 32'(lat), 32'(24));
    check("press_after_reset edges", 32'(edges), 32'(1));

    // Randomized requests, including many offered while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1 req_valid = ($urandom_range(0, 5) == 0);
      req_level = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || cyc_busy); i++) @(negedge clk);
    @(negedge clk);
    check("drained busy", 32'(busy), 32'(0));
    check("enough accepts", 32'(n_accepts >= 30), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the run must end on its own
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Switch-bounce emulator: converts a clean requested switch level into a realistic bouncing waveform on `sw`.
- Pseudo-random glitch durations come from an LFSR; after a bounded bounce window the output settles to the requested level.
- Drives the debouncer's `sw` input in board-level self-test and in the debouncer bench.
- Stimulus side of the same switch interface the debouncers consume.

Parameters:
- TICK_DIV, 100000: clk cycles per timing tick (1 ms at 100 MHz); must be ≥ 2.
- BOUNCE_MIN_TICKS, 4: minimum bounce window length in ticks; must be ≥ 1.
- RAND_BITS, 3: LFSR bits added to the window; window = BOUNCE_MIN_TICKS + lfsr[RAND_BITS-1:0] ticks.
- SETTLE_TICKS, 20: stable hold time after the window, in ticks, before `settled` pulses; must be ≥ 1.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  input  1: single clock; all state on its rising edge.
- reset  input  1: asynchronous, active-low reset (asserts when 0).
- req_valid  input  1: request strobe.
- req_level  input  1: target settled switch level.
- req_ready  output  1: equals !busy; a request is accepted only when req_valid && req_ready.
- sw  output  1: emulated bouncy switch output (registered, glitch-free per cycle).
- busy  output  1: high in BOUNCE or SETTLE.
- settled  output  1: one-cycle pulse when the SETTLE hold completes.
- edge_cnt  output  8: `sw` toggles in the current or most recent operation; saturates at 255.

Behaviour:
- Reset (reset=0, async): state=IDLE, sw=0, busy=0, settled=0, edge_cnt=0, tick counter=0, lfsr=SEED, target=0. Mid-operation reset aborts immediately with no settled pulse.
- Tick: counter 0..TICK_DIV-1, cleared on accept; `tick` is asserted for one cycle when the counter equals TICK_DIV-1. Runs only when busy.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances once on accept, and on every tick in BOUNCE.
- IDLE, on accept:
  - Latch target=req_level, clear edge_cnt.
  - If target != sw: go to BOUNCE. Load win_cnt = BOUNCE_MIN_TICKS + lfsr[RAND_BITS-1:0] and seg_cnt = 1 + lfsr[15:14], using pre-advance lfsr bits.
  - If target == sw: go to SETTLE directly, no edges.
- BOUNCE, per tick:
  - Decrement win_cnt and seg_cnt.
  - When seg_cnt reaches 0: toggle sw, increment edge_cnt, reload seg_cnt = 1 + lfsr[15:14].
  - When win_cnt reaches 0: force sw=target (counts as an edge only if sw changes), load settle_cnt=SETTLE_TICKS, go to SETTLE. The win_cnt expiry takes priority over a simultaneous segment toggle.
- SETTLE: sw held at target. On each tick decrement settle_cnt; at 0, pulse settled for one cycle and go to IDLE with busy=0 in the same cycle.
- Request handling:
  - req_valid while busy is dropped; no queueing.
  - A request in the cycle settled pulses is dropped, because req_ready is still 0 that cycle.
- Latency:
  - Accept to first possible sw change: at least 1 tick.
  - Accept to settled: (window + SETTLE_TICKS) ticks when bouncing, else SETTLE_TICKS ticks.
  - sw changes only on the cycle after a tick.
- sw never changes in IDLE or SETTLE. Final sw after settled always equals target.

Optional Feature:
- Macro: BOUNCE_GEN_RELEASE_BOUNCE_EN.
- Defined: rising (0→1) and falling (1→0) transitions both bounce as above.
- Undefined: only 0→1 transitions bounce. A 1→0 request forces sw=0 on the cycle after accept (edge_cnt=1) and goes straight to SETTLE. This models a clean-release switch.

Test Plan:
- Sim params TICK_DIV=4, BOUNCE_MIN_TICKS=2, RAND_BITS=2, SETTLE_TICKS=3.
- Reset: hold reset=0 for 3 cycles, release → sw=0, busy=0, req_ready=1, edge_cnt=0. Re-assert reset mid-BOUNCE → sw=0 and busy=0 immediately (asynchronous), no settled pulse.
- Press: req_level=1 accepted → busy=1 next cycle.
  - sw toggles only on post-tick cycles; edge_cnt is odd at the end.
  - sw=1 for the final 3 ticks; settled pulses exactly once, at accept + (2..5 + 3) ticks.
- Same-level request: sw=0, req_level=0 accepted → no sw change, edge_cnt=0, settled pulse 12 cycles after accept (3 ticks).
- Busy drop: issue req_level=0 during BOUNCE of a press → ignored; final sw=1 and a single settled pulse.
- Release, macro undefined: from sw=1, req_level=0 → sw=0 one cycle after accept, edge_cnt=1, settled after 3 ticks. With macro defined, release edge_cnt ≥ 1 and is odd.
- Debouncer loop: feed sw into the debouncer with 100 press/release requests → db toggles exactly once per request that changes the level.
